// File: rtl/i_row_skew_feeder_if.sv
// Loader/array-side bundle for the row skew feeder: vector push handshake, tile control
// and the skewed 9-bit {valid, data} lanes.
interface i_row_skew_feeder_if #(
  parameter int unsigned ROW    = 8,
  parameter int unsigned W_DATA = 8,
  parameter int unsigned W_CNT  = 8
);
  logic [ROW*W_DATA-1:0]     i_data;
  logic                      i_valid;
  logic                      o_ready;
  logic                      i_start;
  logic [W_CNT-1:0]          i_len;
  logic [(W_DATA+1)*ROW-1:0] o_data;
  logic                      o_busy;
  logic                      o_done;

  modport master (
    output i_data, i_valid, i_start, i_len,
    input  o_ready, o_data, o_busy, o_done
  );

  modport slave (
    input  i_data, i_valid, i_start, i_len,
    output o_ready, o_data, o_busy, o_done
  );
endinterface

// File: rtl/i_row_skew_feeder.sv
// Buffers row vectors and streams one tile of them into the array, row i delayed i cycles.
// Each lane is packed as {valid, data}; bubbles and idle lanes carry all zeros.
module i_row_skew_feeder #(
  parameter int unsigned ROW    = 8,
  parameter int unsigned W_DATA = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned W_CNT  = 8
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  i_row_skew_feeder_if.slave    bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned VW = ROW * W_DATA;
  localparam int unsigned LW = W_DATA + 1;
  localparam int unsigned FW = (ROW > 1) ? $clog2(ROW) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

  state_e state_q, state_d;

  logic [VW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [W_CNT-1:0] len_q, cnt_q;
  logic [FW-1:0]    flush_q;
  logic             stage0_valid_q;
  logic [VW-1:0]    stage0_vec_q;
  logic [LW-1:0]    lane [ROW];

  logic full, empty, push, pop, last_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.i_valid && !full;
  assign pop      = (state_q == StStream) && !empty;
  assign last_pop = pop && ((cnt_q + W_CNT'(1)) == len_q);

  // Vector buffer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && push) mem_q[wr_ptr_q] <= bus.i_data;
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.i_start) state_d = (bus.i_len != '0) ? StStream : StDone;
      end
      StStream: begin
        if (last_pop) state_d = (ROW > 1) ? StFlush : StDone;
      end
      StFlush: begin
        if (flush_q == FW'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.o_busy = (state_q != StIdle);
    bus.o_done = (state_q == StDone);
  end

  assign bus.o_ready = !full;

  // Tile length, popped-vector count and flush down-counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      len_q   <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      if (state_q == StIdle && bus.i_start) begin
        len_q <= bus.i_len;
        cnt_q <= '0;
      end
      if (pop) cnt_q <= cnt_q + W_CNT'(1);
      if (state_q == StStream && state_d == StFlush) flush_q <= FW'(ROW - 1);
      else if (state_q == StFlush)                   flush_q <= flush_q - FW'(1);
    end
  end

  // Skew stage 0: a popped vector or an all-zero bubble
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stage0_valid_q <= 1'b0;
      stage0_vec_q   <= '0;
    end else begin
      stage0_valid_q <= pop;
      stage0_vec_q   <= pop ? mem_q[rd_ptr_q] : '0;
    end
  end

  assign lane[0] = {stage0_valid_q, stage0_vec_q[VW-1 -: W_DATA]};

  for (genvar r = 1; r < ROW; r++) begin : g_row
    logic [LW-1:0] chain_q [r];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        for (int k = 0; k < r; k++) chain_q[k] <= '0;
      end else begin
        chain_q[0] <= {stage0_valid_q, stage0_vec_q[W_DATA*(ROW-r)-1 -: W_DATA]};
        for (int k = 1; k < r; k++) chain_q[k] <= chain_q[k-1];
      end
    end

    assign lane[r] = chain_q[r-1];
  end

  always_comb begin
    bus.o_data = '0;
    for (int r = 0; r < ROW; r++) bus.o_data[LW*(ROW-r)-1 -: LW] = lane[r];
  end

endmodule

// File: tb/tb_i_row_skew_feeder.sv
// Directed-plus-random bench for i_row_skew_feeder against a queue/history reference model.
module tb_i_row_skew_feeder;

  localparam int unsigned ROW   = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WC    = 8;
  localparam int unsigned VW    = ROW * W;
  localparam int unsigned LW    = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i_row_skew_feeder_if #(.ROW(ROW), .W_DATA(W), .W_CNT(WC)) bus ();

  i_row_skew_feeder #(.ROW(ROW), .W_DATA(W), .DEPTH(DEPTH), .W_CNT(WC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain vector queue, a tile phase, and the history of what was
  // injected at the head of the array (hist[k] = injection k+1 cycles ago).
  logic [VW-1:0] mq [$];
  int            ph;          // 0 idle, 1 streaming, 2 flushing, 3 done
  int            remaining;
  int            flush_left;
  logic [VW:0]   hist [ROW];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [LW*ROW-1:0] e;
    e = '0;
    for (int r = 0; r < ROW; r++)
      e[LW*(ROW-r)-1 -: LW] = {hist[r][VW], hist[r][W*(ROW-r)-1 -: W]};
    chk("o_data",  64'(bus.o_data),  64'(e));
    chk("o_busy",  64'(bus.o_busy),  64'(ph != 0));
    chk("o_done",  64'(bus.o_done),  64'(ph == 3));
    chk("o_ready", 64'(bus.o_ready), 64'(mq.size() != DEPTH));
  endtask

  task automatic model_update();
    bit            pop;
    bit            ready;
    logic [VW-1:0] front;
    if (!rst_n) begin
      mq.delete();
      ph = 0;
      remaining = 0;
      flush_left = 0;
      for (int r = 0; r < ROW; r++) hist[r] = '0;
    end else begin
      ready = (mq.size() != DEPTH);
      pop   = (ph == 1) && (mq.size() > 0);
      front = pop ? mq[0] : '0;
      if (pop) void'(mq.pop_front());
      if (bus.i_valid && ready) mq.push_back(bus.i_data);
      for (int r = ROW - 1; r > 0; r--) hist[r] = hist[r-1];
      hist[0] = pop ? {1'b1, front} : '0;
      case (ph)
        0: if (bus.i_start) begin
             if (bus.i_len != 0) begin
               ph = 1;
               remaining = int'(bus.i_len);
             end else begin
               ph = 3;
             end
           end
        1: if (pop) begin
             remaining--;
             if (remaining == 0) begin
               ph = 2;
               flush_left = ROW - 1;
             end
           end
        2: begin
             flush_left--;
             if (flush_left == 0) ph = 3;
           end
        default: ph = 0;
      endcase
    end
  endtask

  // Check settled outputs mid-cycle, then advance the model on the active edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push1(input logic [VW-1:0] v);
    bus.i_valid = 1'b1;
    bus.i_data  = v;
    step();
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
  endtask

  task automatic start_tile(input int l);
    bus.i_start = 1'b1;
    bus.i_len   = WC'(l);
    step();
    bus.i_start = 1'b0;
    bus.i_len   = '0;
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return VW'($urandom());
  endfunction

  initial begin
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_start = 1'b0;
    bus.i_len   = '0;
    @(posedge clk);
    model_update();
    #1;
    step();
    rst_n = 1'b1;
    run(2);

    // Three fixed vectors, tile of 3
    push1(32'h01020304);
    push1(32'h11121314);
    push1(32'h21222324);
    start_tile(3);
    run(12);

    // Tile of 4 with only 2 vectors ready; the rest arrive after a gap
    push1(rnd_vec());
    push1(rnd_vec());
    start_tile(4);
    run(5);
    push1(rnd_vec());
    push1(rnd_vec());
    run(10);

    // Fill the buffer, one extra push is dropped, then stream all 16
    for (int i = 0; i < DEPTH + 1; i++) push1(rnd_vec());
    run(2);
    start_tile(16);
    run(26);

    // Zero-length tile, then a restart attempt during streaming
    start_tile(0);
    run(3);
    push1(rnd_vec());
    push1(rnd_vec());
    push1(rnd_vec());
    start_tile(2);
    bus.i_start = 1'b1;
    bus.i_len   = WC'(1);
    step();
    bus.i_start = 1'b0;
    bus.i_len   = '0;
    run(8);
    start_tile(1);
    run(8);

    // Reset in the middle of streaming, then a 1-vector tile
    for (int i = 0; i < 4; i++) push1(rnd_vec());
    start_tile(4);
    run(3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(2);
    push1(rnd_vec());
    start_tile(1);
    run(8);

    // Steady push and pop with DEPTH-1 entries buffered
    for (int i = 0; i < DEPTH - 1; i++) push1(rnd_vec());
    start_tile(40);
    bus.i_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      bus.i_data = rnd_vec();
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    run(25);

    // Random tiles with random push traffic
    for (int t = 0; t < 5; t++) begin
      int l;
      l = int'($urandom_range(1, 12));
      bus.i_start = 1'b1;
      bus.i_len   = WC'(l);
      for (int c = 0; c < l + ROW + 10; c++) begin
        bus.i_valid = 1'($urandom_range(0, 1));
        bus.i_data  = rnd_vec();
        step();
        bus.i_start = 1'b0;
      end
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      run(int'($urandom_range(0, 3)));
    end
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i_row_skew_feeder.md
Name: i_row_skew_feeder

Overview:
Input-side counterpart of the output row FIFO bank. It buffers full row vectors (ROW x W_DATA) from the loader and streams one tile of i_len vectors into the systolic array rows. The lanes are diagonally skewed: row i is delayed i cycles relative to row 0. Each row lane is packed as a 9-bit {valid, data} word, the same per-row lane format the output FIFO bank consumes.

Parameters:
ROW, 8, number of array rows / output lanes
W_DATA, 8, data width per row; the lane format is fixed at 9 bits, so W_DATA must be 8
DEPTH, 16, vector buffer depth (entries, power of 2)
W_CNT, 8, width of tile-length counter

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_data  input  ROW*W_DATA  row vector; row i at bits [W_DATA*(ROW-i)-1 -: W_DATA]
i_valid  input  1  push request for i_data
o_ready  output  1  buffer can accept (= not full)
i_start  input  1  start a tile (sampled only in IDLE)
i_len  input  W_CNT  vectors in tile, latched on accepted i_start
o_data  output  9*ROW  skewed lanes; row i at bits [9*(ROW-i)-1 -: 9], MSB = valid, low 8 = data
o_busy  output  1  high when state != IDLE
o_done  output  1  one-cycle pulse at tile completion

Behaviour:
- Reset (i_rst_n=0 at clock edge):
  - buffer pointers/count = 0; all skew registers = 0; o_data = 0; state = IDLE; o_done = 0; tile counter = 0.
  - o_ready = 1 from the cycle after reset.
- Buffer:
  - DEPTH-entry FIFO of ROW*W_DATA vectors; o_ready = (count != DEPTH).
  - Push when i_valid && o_ready. Push while full is dropped with no state change.
  - Push is allowed in any state, including during streaming.
  - Simultaneous push and pop: count unchanged; data ordering preserved.
- State machine (IDLE, STREAM, FLUSH, DONE):
  - IDLE:
    - i_start && i_len != 0: latch len, clear tile counter, go to STREAM.
    - i_start && i_len == 0: go to DONE directly; no lane ever goes valid.
  - STREAM, each cycle:
    - If buffer non-empty: pop one vector, inject it into skew stage 0 with valid=1, increment counter.
    - If buffer empty: inject a bubble (valid=0, data=0); counter holds.
    - When the pop that makes counter == len occurs, go to FLUSH.
  - FLUSH: inject bubbles for exactly ROW-1 cycles (down-counter), then go to DONE.
  - DONE: o_done=1 for this one cycle, then go to IDLE.
  - i_start outside IDLE is ignored.
- Skew:
  - Stage-0 register holds {valid, vector}.
  - Row i lane = row i slice of the stage-0 entry, delayed by i further registers (per-row shift chain of depth i).
  - Vector popped in cycle t: row 0 valid at t+1, row i valid at t+1+i. Row ROW-1 of the last vector is valid in the final FLUSH cycle's output edge, before o_done.
  - Invalid lanes drive data = 0.
- o_busy is combinational from state: high in STREAM, FLUSH and DONE.
- Reset mid-tile clears everything immediately, including in-flight skew data. No o_done is generated for the aborted tile.
- Arithmetic:
  - Counter compare is unsigned W_CNT bits.
  - Max tile = 2^W_CNT - 1 vectors.
  - Buffer pointers wrap modulo DEPTH.

Test Plan:
- ROW=4, preload 3 vectors (row bytes 0x01..0x04, 0x11..0x14, 0x21..0x24), i_start with i_len=3 -> row0 lane valid at t+1..t+3 with 0x01,0x11,0x21; row3 lane valid at t+4..t+6 with 0x04,0x14,0x24; all lanes 0 otherwise; o_done pulses once, the cycle after FLUSH ends; o_busy low afterwards.
- i_len=4, only 2 vectors preloaded, 3rd/4th pushed 5 cycles later -> bubbles (valid=0, data=0) on row0 during the gap; counter holds; all 4 vectors are emitted in order with correct skew; exactly one o_done.
- Fill DEPTH=16 entries with no tile running -> o_ready=0; a 17th push is dropped. Start tile i_len=16 -> 16 distinct vectors emitted, no duplicate or lost entry; o_ready returns to 1 after the first pop.
- i_start with i_len=0 -> o_busy high for 1 cycle (DONE), o_done pulses, no lane ever valid. A second i_start during STREAM of a subsequent tile is ignored (len unchanged).
- Assert i_rst_n=0 mid-STREAM with valid data in the skew chain -> next cycle o_data=0, state IDLE, o_done=0, o_ready=1, buffer empty (a following 1-vector tile outputs only the new data).
- Continuous push and pop each cycle at count=DEPTH-1 during STREAM -> count stays at DEPTH-1, output order matches input order.
